mux_32_8: RTL and testbench



---
 rtl/mux_32_8.sv | 108 ++++++++++
 tb/tb_mux_32_8.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_32_8.sv
// rtl/mux_32_8.sv - 32-to-8 transmit serializer, MSB byte first, one-word holding register
//
// Purpose: accepts 32-bit words on a valid/ready handshake and emits them as
// four 8-bit bytes (bits 31:24 first), one byte per clk_4f cycle. A one-word
// holding register allows gapless streaming at one word per four cycles.
//
// Ports:
//   clk_4f     in   1   byte-rate clock, rising edge
//   reset      in   1   asynchronous, active-high
//   data_in    in   32  word to serialize, sampled on acceptance
//   valid      in   1   data_in holds a word
//   ready      out  1   block can take a word this cycle (registered)
//   data_out   out  8   current byte, idle value when valid_out is low
//   valid_out  out  1   data_out carries a payload byte (registered)
//
// Configuration macro: MUX_IDLE_BC_EN
//   defined   -> idle value on data_out is 8'hBC (COM symbol)
//   undefined -> idle value on data_out is 8'h00

module mux_32_8 (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid,
  output logic        ready,
  output logic [7:0]  data_out,
  output logic        valid_out
);

`ifdef MUX_IDLE_BC_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] sh;
  logic [31:0] hold;
  logic        hold_v;

  logic        accept;
  logic        free;
  logic [31:0] load_word;
  logic [1:0]  idx_next;

  // ready mirrors ~hold_v as its own flop, so acceptance never depends
  // combinationally on valid.
  assign accept    = valid && ready;
  // The shifter can take a new word when idle or when the last byte is out.
  assign free      = (state == IDLE) || (idx == 2'd3);
  // A held word always wins over the input; ready is low while one is held.
  assign load_word = hold_v ? hold : data_in;
  assign idx_next  = idx + 2'd1;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      sh        <= 32'h0;
      hold      <= 32'h0;
      hold_v    <= 1'b0;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      data_out  <= IDLE_BYTE;
    end else if (free) begin
      if (hold_v || accept) begin
        state     <= SEND;
        idx       <= 2'd0;
        sh        <= load_word;
        data_out  <= load_word[31:24];
        valid_out <= 1'b1;
        if (hold_v) begin
          hold_v <= 1'b0;
          ready  <= 1'b1;
        end
      end else begin
        state     <= IDLE;
        idx       <= 2'd0;
        valid_out <= 1'b0;
        data_out  <= IDLE_BYTE;
      end
    end else begin
      idx      <= idx_next;
      data_out <= byte_sel(sh, idx_next);
      // Only reachable with hold_v low, so the holding register never overflows.
      if (accept) begin
        hold   <= data_in;
        hold_v <= 1'b1;
        ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_32_8.sv
// tb/tb_mux_32_8.sv - scoreboard testbench for mux_32_8

module tb_mux_32_8;

`ifdef MUX_IDLE_BC_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid;
  logic        ready;
  logic [7:0]  data_out;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  mux_32_8 dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid     (valid),
    .ready     (ready),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Monitor: every payload byte must match the next expected byte.
  always @(negedge clk_4f) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("byte", {24'h0, data_out}, {24'h0, e});
      end
    end
  end

  // Streams n words with valid held high on a hand-derived schedule:
  // word 0 at edge 0, word 1 at edge 1, word j at edge 1+4(j-1).
  // Checks gapless valid_out and the ready pattern after each edge.
  task automatic stream(input logic [31:0] w[], input int n);
    int last_acc;
    last_acc = (n == 1) ? 0 : 1 + 4 * (n - 2);
    for (int j = 0; j < n; j++) push_word(w[j]);
    for (int c = 0; c < 4 * n; c++) begin
      if (c <= last_acc) begin
        valid   = 1'b1;
        data_in = w[(c == 0) ? 0 : (c + 3) / 4];
      end else begin
        valid   = 1'b0;
        data_in = 32'h5A5A_5A5A;
      end
      @(negedge clk_4f);
      check("stream_valid_out", {31'h0, valid_out}, 32'h1);
      check("stream_ready", {31'h0, ready},
            {31'h0, ((c % 4) == 0) || (c >= 4 * (n - 1))});
    end
    valid = 1'b0;
    @(negedge clk_4f);
    check("idle_valid_out", {31'h0, valid_out}, 32'h0);
    check("idle_data_out", {24'h0, data_out}, {24'h0, IDLE_BYTE});
    check("idle_ready", {31'h0, ready}, 32'h1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < 50) begin
      @(negedge clk_4f);
      n++;
    end
    check("drain_timeout", {31'h0, n >= 50}, 32'h0);
  endtask

  logic [31:0] words[];
  logic [31:0] bp[6];

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    data_in = 32'h0;
    #1;
    check("reset_valid_out", {31'h0, valid_out}, 32'h0);
    check("reset_ready", {31'h0, ready}, 32'h1);
    check("reset_data_out", {24'h0, data_out}, {24'h0, IDLE_BYTE});
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;

    // Single word
    words = new[1];
    words[0] = 32'hA1B2C3D4;
    stream(words, 1);
    drain();

    // Streaming, three words back to back
    words = new[3];
    words[0] = 32'h00112233;
    words[1] = 32'h44556677;
    words[2] = 32'h8899AABB;
    stream(words, 3);
    drain();

    // Backpressure: data_in changes every cycle; accepted at edges 0, 1, 5
    bp = '{32'h10203040, 32'h50607080, 32'hDEAD0002, 32'hDEAD0003,
           32'hDEAD0004, 32'h90A0B0C0};
    push_word(bp[0]);
    push_word(bp[1]);
    push_word(bp[5]);
    for (int c = 0; c < 6; c++) begin
      valid   = 1'b1;
      data_in = bp[c];
      @(negedge clk_4f);
    end
    valid = 1'b0;
    drain();

    // Reset mid-word after second byte of DEADBEEF
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    valid   = 1'b1;
    data_in = 32'hDEADBEEF;
    @(negedge clk_4f);
    valid = 1'b0;
    @(negedge clk_4f);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid_out", {31'h0, valid_out}, 32'h0);
    check("async_reset_ready", {31'h0, ready}, 32'h1);
    check("async_reset_data_out", {24'h0, data_out}, {24'h0, IDLE_BYTE});
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
    check("reset_queue_empty", exp_q.size(), 32'h0);
    words = new[1];
    words[0] = 32'h01020304;
    stream(words, 1);
    drain();

    // Long random stream
    words = new[16];
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    stream(words, 16);
    drain();

    check("final_queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
